frame_issuer: RTL and testbench
===============================

// Module: frame_issuer
// PURPOSE
//  Instruction-side counterpart of the oak CPU core: holds a small program store, fetches 17-bit
//  frames {opcode[16:13], operands[12:0]} and drives them to the core's frame input with valid/ready.
//  Resolves JMP (4'hC) locally; takes conditional redirects (JNE/JEQ outcome) back from the core.
//  Sits between the host/loader and the core; one clock domain.
// PARAMETERS
//  ADDR_W     8      program address width; store depth = 2**ADDR_W frames; pc width = ADDR_W
//  MAX_ISSUE  1024   watchdog: max frames accepted per run before forced stop (loop guard)
// PORTS
//  sysclk         in   1         system clock, all logic on rising edge
//  reset          in   1         synchronous, active-high
//  prog_we        in   1         program store write strobe (honoured only in IDLE/DONE)
//  prog_addr      in   ADDR_W    program store write address
//  prog_wdata     in   17        frame to store
//  prog_len       in   ADDR_W+1  number of valid frames; sampled on start
//  start          in   1         begin run at pc 0 (honoured only in IDLE/DONE)
//  halt_req       in   1         abort current run
//  frame_out      out  17        frame to core
//  frame_valid    out  1         frame_out valid
//  frame_ready    in   1         core accepts frame this cycle
//  redirect_valid in   1         core reports taken branch
//  redirect_pc    in   ADDR_W    branch target
//  pc_out         out  ADDR_W    address of frame currently fetched/presented
//  busy           out  1         high in FETCH/ISSUE
//  done           out  1         high in DONE
//  timeout        out  1         run ended by watchdog; cleared on start
//  issue_count    out  16        frames accepted this run; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state IDLE; frame_out=0, frame_valid=0, pc_out=0, busy=0, done=0, timeout=0,
//   issue_count=0. Program store contents are NOT cleared by reset.
//  Store: 1 write/cycle when prog_we and state in {IDLE,DONE}; writes in FETCH/ISSUE dropped.
//   Read is registered (1-cycle latency).
//  FSM IDLE/DONE --start--> FETCH: pc=0, issue_count=0, timeout=0, len latched.
//   start with latched len=0 -> DONE next cycle, no frame issued.
//  FETCH (1 cycle): read store[pc] -> ISSUE; frame_valid rises the following cycle.
//  ISSUE: frame_out/frame_valid held stable while frame_ready=0 (no change under backpressure).
//   Accept = frame_valid & frame_ready. On accept: issue_count+1; next_pc = frame_out[12:5]
//   if opcode==4'hC else pc+1 (mod 2**ADDR_W); frame_valid drops.
//   If next_pc >= len -> DONE; elif issue_count+1 == MAX_ISSUE -> DONE with timeout=1;
//   else pc=next_pc -> FETCH. Steady state: one frame per 2 cycles at frame_ready=1.
//  Redirect (FETCH or ISSUE): pc=redirect_pc, unaccepted frame discarded (frame_valid=0
//   next cycle), -> FETCH (or DONE if redirect_pc >= len). Same cycle as accept: accept counts,
//   redirect_pc overrides next_pc. Ignored in IDLE/DONE.
//  halt_req in FETCH/ISSUE -> DONE next cycle, frame_valid=0; a same-cycle accept still counts.
//   Priority: reset > halt_req > redirect > accept.
//  done held until start; busy = state in {FETCH,ISSUE}.
// TESTING
//  1. Load 3 frames 0x02A00,0x04C00,0x06E02, len=3, ready=1, start -> 3 frames in order every
//     2 cycles, then done=1, issue_count=3, timeout=0.
//  2. Frame 0 = JMP to 5 (0x18000|5<<5), len=8 -> next frame issued is store[5], pc_out=5.
//  3. Hold frame_ready=0 for 10 cycles in ISSUE -> frame_out/frame_valid unchanged; count unchanged.
//  4. redirect_valid with redirect_pc=2 during ISSUE of pc=4 -> frame 4 dropped, next frame store[2];
//     redirect_pc=9 with len=8 -> DONE.
//  5. MAX_ISSUE=4, frame 0 = JMP to 0, len=4 -> done=1, timeout=1, issue_count=4.
//  6. reset mid-ISSUE -> all outputs at reset values next cycle; restart -> original program replays.

Source files
------------

// File: rtl/frame_issuer.sv
// frame_issuer: program store plus fetch/issue sequencer feeding 17-bit frames
// {opcode[16:13], operands[12:0]} to the core over a valid/ready handshake.
// JMP (4'hC) is resolved locally; taken conditional branches come back on redirect_*.
// Ports:
//   sysclk, reset                     clock, synchronous active-high reset
//   prog_we/prog_addr/prog_wdata      program store write port (IDLE/DONE only)
//   prog_len, start, halt_req         run control; length latched on start
//   frame_out/frame_valid/frame_ready frame handshake toward the core
//   redirect_valid/redirect_pc        taken-branch feedback from the core
//   pc_out, busy, done, timeout       status
//   issue_count                       frames accepted this run (saturating)
module frame_issuer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_ISSUE = 1024
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [16:0]       prog_wdata,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              halt_req,
    output logic [16:0]       frame_out,
    output logic              frame_valid,
    input  logic              frame_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       issue_count
);

    localparam int unsigned FRAME_W = 17;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [3:0]       OP_JMP  = 4'hC;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]      WD_LAST = 32'(MAX_ISSUE) - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W:0]      len_q, len_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [FRAME_W-1:0]   mem_q [DEPTH];

    logic                 accept_c;
    logic                 wd_hit_c;
    logic                 next_end_c;
    logic                 redir_end_c;
    logic [ADDR_W-1:0]    next_pc_c;
    logic [CNT_W-1:0]     cnt_inc_c;

    // Program store: not cleared by reset, writable only while no run is active
    always_ff @(posedge sysclk) begin
        if (prog_we && (state_q == S_IDLE || state_q == S_DONE)) begin
            mem_q[prog_addr] <= prog_wdata;
        end
    end

    // State and output registers
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; priority halt_req > redirect > accept
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        frame_d   = frame_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        accept_c    = (state_q == S_ISSUE) && valid_q && frame_ready;
        cnt_inc_c   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        wd_hit_c    = (32'(cnt_q) == WD_LAST);
        next_pc_c   = (frame_q[16:13] == OP_JMP) ? ADDR_W'(frame_q[12:5])
                                                 : pc_q + ADDR_W'(1);
        next_end_c  = ({1'b0, next_pc_c} >= len_q);
        redir_end_c = ({1'b0, redirect_pc} >= len_q);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d      = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    len_d     = prog_len;
                    valid_d   = 1'b0;
                    state_d   = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (halt_req) begin
                    state_d = S_DONE;
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = redir_end_c ? S_DONE : S_FETCH;
                end else begin
                    frame_d = mem_q[pc_q];
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An accept in the same cycle as halt/redirect still counts
                if (accept_c) begin
                    cnt_d = cnt_inc_c;
                end
                if (halt_req) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end else if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                    if (redir_end_c) begin
                        state_d = S_DONE;
                    end else if (accept_c && wd_hit_c) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (accept_c) begin
                    valid_d = 1'b0;
                    if (next_end_c) begin
                        state_d = S_DONE;
                    end else if (wd_hit_c) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        pc_d    = next_pc_c;
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_ISSUE);
        done_d = (state_d == S_DONE);
    end

    assign frame_out   = frame_q;
    assign frame_valid = valid_q;
    assign pc_out      = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_frame_issuer.sv
// Bench for frame_issuer: directed scenarios plus randomized programs checked
// against a program-walk reference model. A second instance with a tiny
// watchdog limit shares all inputs.
module tb_frame_issuer;

    logic        sysclk;
    logic        reset;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [16:0] prog_wdata;
    logic [8:0]  prog_len;
    logic        start;
    logic        halt_req;
    logic        frame_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    logic [16:0] frame_out,   frame_out_w;
    logic        frame_valid, frame_valid_w;
    logic [7:0]  pc_out,      pc_out_w;
    logic        busy,        busy_w;
    logic        done,        done_w;
    logic        timeout,     timeout_w;
    logic [15:0] issue_count, issue_count_w;

    frame_issuer #(.ADDR_W(8), .MAX_ISSUE(1024)) dut (
        .sysclk(sysclk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .halt_req(halt_req),
        .frame_out(frame_out), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc_out(pc_out),
        .busy(busy), .done(done), .timeout(timeout), .issue_count(issue_count)
    );

    frame_issuer #(.ADDR_W(8), .MAX_ISSUE(4)) dut_wd (
        .sysclk(sysclk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .halt_req(halt_req),
        .frame_out(frame_out_w), .frame_valid(frame_valid_w), .frame_ready(frame_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc_out(pc_out_w),
        .busy(busy_w), .done(done_w), .timeout(timeout_w), .issue_count(issue_count_w)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;

    logic [16:0] prog [256];
    logic [16:0] got_f [$];
    logic [7:0]  got_pc [$];
    int          got_step [$];
    logic [16:0] exp_f [$];
    logic [7:0]  exp_pc [$];
    int          exp_cnt;
    bit          exp_to;
    int          stab_err;
    bit          run_to;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            prog_we = 1'b1; prog_addr = 8'(i); prog_wdata = prog[i];
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic kick(input int len);
        prog_len = 9'(len); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Reference: walk the program by its rules, independent of cycle timing
    task automatic model_run(input int len, input int max_issue);
        int pc;
        int nxt;
        exp_f.delete(); exp_pc.delete(); exp_cnt = 0; exp_to = 0;
        pc = 0;
        if (len == 0) return;
        forever begin
            exp_f.push_back(prog[pc]);
            exp_pc.push_back(8'(pc));
            exp_cnt++;
            if (prog[pc][16:13] == 4'hC) nxt = int'(prog[pc][12:5]);
            else nxt = (pc + 1) % 256;
            if (nxt >= len) break;
            if (exp_cnt == max_issue) begin exp_to = 1; break; end
            pc = nxt;
        end
    endtask

    // Drives frame_ready randomly and records accepted frames until done
    task automatic collect(input int pct, input int budget);
        bit prev_stall;
        logic [16:0] prev_f;
        got_f.delete(); got_pc.delete(); got_step.delete();
        stab_err = 0; run_to = 1; prev_stall = 0; prev_f = '0;
        for (int n = 0; n < budget; n++) begin
            if (done) begin run_to = 0; break; end
            if (prev_stall && (frame_valid !== 1'b1 || frame_out !== prev_f)) stab_err++;
            frame_ready = (int'($urandom_range(0, 99)) < pct);
            if (frame_valid && frame_ready) begin
                got_f.push_back(frame_out);
                got_pc.push_back(pc_out);
                got_step.push_back(n);
            end
            prev_stall = frame_valid && !frame_ready;
            prev_f = frame_out;
            step();
        end
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++; if (frame_out !== 17'd0) begin errors++; $display("FAIL reset_frame_out got=%0h exp=0", frame_out); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", frame_valid); end
        checks++; if (pc_out !== 8'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        checks++; if (issue_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", issue_count); end
    endtask

    task automatic test_basic();
        logic [16:0] e [3];
        e[0] = 17'h02A00; e[1] = 17'h04C00; e[2] = 17'h06E02;
        for (int i = 0; i < 3; i++) prog[i] = e[i];
        load_prog(3);
        kick(3);
        checks++; if (busy !== 1'b1 || frame_valid !== 1'b0) begin errors++; $display("FAIL basic_fetch busy=%0b valid=%0b exp busy=1 valid=0", busy, frame_valid); end
        collect(100, 50);
        checks++; if (run_to !== 1'b0) begin errors++; $display("FAIL basic_budget ran out of cycles"); end
        checks++; if (got_f.size() !== 3) begin errors++; $display("FAIL basic_nframes got=%0d exp=3", got_f.size()); end
        for (int i = 0; i < 3 && i < got_f.size(); i++) begin
            checks++; if (got_f[i] !== e[i]) begin errors++; $display("FAIL basic_frame%0d got=%0h exp=%0h", i, got_f[i], e[i]); end
            checks++; if (got_step[i] !== 1 + 2 * i) begin errors++; $display("FAIL basic_cadence%0d got=%0d exp=%0d", i, got_step[i], 1 + 2 * i); end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done done=%0b busy=%0b exp 1/0", done, busy); end
        checks++; if (issue_count !== 16'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", issue_count); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%0b exp=0", timeout); end
    endtask

    task automatic test_jump();
        prog[0] = 17'h18000 | (17'd5 << 5);
        for (int i = 1; i < 8; i++) prog[i] = 17'h02000 | 17'(i * 3);
        load_prog(8);
        kick(8);
        collect(100, 100);
        model_run(8, 1024);
        checks++; if (got_f.size() !== exp_f.size()) begin errors++; $display("FAIL jump_nframes got=%0d exp=%0d", got_f.size(), exp_f.size()); end
        checks++; if (got_f.size() < 2 || got_f[1] !== prog[5]) begin errors++; $display("FAIL jump_target_frame got=%0h exp=%0h", (got_f.size() > 1) ? got_f[1] : 17'h0, prog[5]); end
        checks++; if (got_pc.size() < 2 || got_pc[1] !== 8'd5) begin errors++; $display("FAIL jump_target_pc got=%0d exp=5", (got_pc.size() > 1) ? got_pc[1] : 8'h0); end
        checks++; if (issue_count !== 16'(exp_cnt)) begin errors++; $display("FAIL jump_count got=%0d exp=%0d", issue_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        int n;
        kick(8);
        frame_ready = 1'b0;
        n = 0;
        while (frame_valid !== 1'b1 && n < 5) begin step(); n++; end
        for (int i = 0; i < 10; i++) begin
            checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%0b exp=1", i, frame_valid); end
            checks++; if (frame_out !== prog[0]) begin errors++; $display("FAIL bp_frame%0d got=%0h exp=%0h", i, frame_out, prog[0]); end
            checks++; if (issue_count !== 16'd0) begin errors++; $display("FAIL bp_count%0d got=%0d exp=0", i, issue_count); end
            step();
        end
        collect(100, 100);
        checks++; if (issue_count !== 16'd4 || done !== 1'b1) begin errors++; $display("FAIL bp_finish count=%0d done=%0b exp 4/1", issue_count, done); end
    endtask

    task automatic test_redirect();
        int n;
        for (int i = 0; i < 8; i++) prog[i] = 17'h04000 | 17'($urandom_range(0, 8191));
        load_prog(8);
        kick(8);
        frame_ready = 1'b1;
        n = 0;
        while (!(frame_valid === 1'b1 && pc_out === 8'd4) && n < 40) begin step(); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL redir_reach_pc4 got pc=%0d exp=4", pc_out); end
        frame_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'd2;
        step();
        redirect_valid = 1'b0;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL redir_drop got valid=%0b exp=0", frame_valid); end
        checks++; if (issue_count !== 16'd4) begin errors++; $display("FAIL redir_count got=%0d exp=4", issue_count); end
        n = 0;
        while (frame_valid !== 1'b1 && n < 5) begin step(); n++; end
        checks++; if (frame_out !== prog[2] || frame_valid !== 1'b1) begin errors++; $display("FAIL redir_frame got=%0h exp=%0h", frame_out, prog[2]); end
        checks++; if (pc_out !== 8'd2) begin errors++; $display("FAIL redir_pc got=%0d exp=2", pc_out); end
        redirect_valid = 1'b1; redirect_pc = 8'd9;
        step();
        redirect_valid = 1'b0;
        checks++; if (done !== 1'b1 || frame_valid !== 1'b0) begin errors++; $display("FAIL redir_past_len done=%0b valid=%0b exp 1/0", done, frame_valid); end
        checks++; if (issue_count !== 16'd4) begin errors++; $display("FAIL redir_past_len_count got=%0d exp=4", issue_count); end
    endtask

    task automatic test_watchdog();
        int n;
        prog[0] = 17'h18000;
        for (int i = 1; i < 4; i++) prog[i] = 17'h02000 | 17'(i);
        load_prog(4);
        kick(4);
        frame_ready = 1'b1;
        n = 0;
        while (done_w !== 1'b1 && n < 40) begin step(); n++; end
        checks++; if (done_w !== 1'b1) begin errors++; $display("FAIL wd_done got=%0b exp=1", done_w); end
        checks++; if (timeout_w !== 1'b1) begin errors++; $display("FAIL wd_timeout got=%0b exp=1", timeout_w); end
        checks++; if (issue_count_w !== 16'd4) begin errors++; $display("FAIL wd_count got=%0d exp=4", issue_count_w); end
        n = 0;
        while (done !== 1'b1 && n < 2300) begin step(); n++; end
        checks++; if (done !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL wd1024_end done=%0b timeout=%0b exp 1/1", done, timeout); end
        checks++; if (issue_count !== 16'd1024) begin errors++; $display("FAIL wd1024_count got=%0d exp=1024", issue_count); end
        frame_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        kick(0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_done done=%0b busy=%0b exp 1/0", done, busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL len0_timeout_clear got=%0b exp=0", timeout); end
        checks++; if (issue_count !== 16'd0) begin errors++; $display("FAIL len0_count got=%0d exp=0", issue_count); end
        step();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL len0_valid got=%0b exp=0", frame_valid); end
    endtask

    task automatic test_halt();
        int n;
        for (int i = 0; i < 8; i++) prog[i] = 17'h06000 | 17'(i);
        load_prog(8);
        kick(8);
        frame_ready = 1'b1;
        n = 0;
        while (!(frame_valid === 1'b1 && pc_out === 8'd2) && n < 40) begin step(); n++; end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0; frame_ready = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL halt_done done=%0b busy=%0b exp 1/0", done, busy); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got=%0b exp=0", frame_valid); end
        checks++; if (issue_count !== 16'd3) begin errors++; $display("FAIL halt_count got=%0d exp=3", issue_count); end
    endtask

    task automatic test_write_guard();
        int n;
        for (int i = 0; i < 4; i++) prog[i] = 17'h08000 | 17'(i + 16);
        load_prog(4);
        kick(4);
        frame_ready = 1'b0;
        n = 0;
        while (frame_valid !== 1'b1 && n < 5) begin step(); n++; end
        prog_we = 1'b1; prog_addr = 8'd2; prog_wdata = 17'h1FFFF;
        step();
        prog_we = 1'b0;
        collect(100, 50);
        checks++; if (got_f.size() < 3 || got_f[2] !== prog[2]) begin errors++; $display("FAIL wguard_frame got=%0h exp=%0h", (got_f.size() > 2) ? got_f[2] : 17'h0, prog[2]); end
    endtask

    task automatic test_random();
        int len;
        int op;
        for (int it = 0; it < 8; it++) begin
            len = int'($urandom_range(1, 24));
            for (int pc = 0; pc < len; pc++) begin
                op = int'($urandom_range(0, 15));
                if (op == 12) prog[pc] = {4'hC, 8'($urandom_range(pc + 1, len + 3)), 5'($urandom)};
                else prog[pc] = {4'(op), 13'($urandom)};
            end
            load_prog(len);
            kick(len);
            collect(int'($urandom_range(30, 100)), 600);
            model_run(len, 1024);
            checks++; if (run_to !== 1'b0) begin errors++; $display("FAIL rnd%0d_budget ran out of cycles", it); end
            checks++; if (got_f.size() !== exp_f.size()) begin errors++; $display("FAIL rnd%0d_nframes got=%0d exp=%0d", it, got_f.size(), exp_f.size()); end
            for (int i = 0; i < exp_f.size() && i < got_f.size(); i++) begin
                checks++; if (got_f[i] !== exp_f[i] || got_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL rnd%0d_frame%0d got=%0h@%0d exp=%0h@%0d", it, i, got_f[i], got_pc[i], exp_f[i], exp_pc[i]); end
            end
            checks++; if (stab_err !== 0) begin errors++; $display("FAIL rnd%0d_stability got=%0d changes exp=0", it, stab_err); end
            checks++; if (issue_count !== 16'(exp_cnt) || timeout !== exp_to) begin errors++; $display("FAIL rnd%0d_count got=%0d/%0b exp=%0d/%0b", it, issue_count, timeout, exp_cnt, exp_to); end
            model_run(len, 4);
            checks++; if (issue_count_w !== 16'(exp_cnt) || timeout_w !== exp_to || done_w !== 1'b1) begin errors++; $display("FAIL rnd%0d_wd got=%0d/%0b exp=%0d/%0b", it, issue_count_w, timeout_w, exp_cnt, exp_to); end
        end
    endtask

    task automatic test_reset_replay();
        int n;
        for (int i = 0; i < 6; i++) prog[i] = {4'(i + 1), 13'($urandom)};
        load_prog(6);
        kick(6);
        frame_ready = 1'b1;
        n = 0;
        while (!(frame_valid === 1'b1 && pc_out === 8'd2) && n < 40) begin step(); n++; end
        frame_ready = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (frame_valid !== 1'b0 || frame_out !== 17'd0 || pc_out !== 8'd0) begin errors++; $display("FAIL rst_mid_frame valid=%0b frame=%0h pc=%0d exp 0/0/0", frame_valid, frame_out, pc_out); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || issue_count !== 16'd0) begin errors++; $display("FAIL rst_mid_status busy=%0b done=%0b to=%0b cnt=%0d exp all 0", busy, done, timeout, issue_count); end
        kick(6);
        collect(60, 200);
        model_run(6, 1024);
        checks++; if (got_f.size() !== exp_f.size()) begin errors++; $display("FAIL replay_nframes got=%0d exp=%0d", got_f.size(), exp_f.size()); end
        for (int i = 0; i < exp_f.size() && i < got_f.size(); i++) begin
            checks++; if (got_f[i] !== exp_f[i]) begin errors++; $display("FAIL replay_frame%0d got=%0h exp=%0h", i, got_f[i], exp_f[i]); end
        end
    endtask

    initial begin
        sysclk = 1'b0; reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        prog_len = '0; start = 1'b0; halt_req = 1'b0; frame_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_basic();
        test_jump();
        test_backpressure();
        test_redirect();
        test_watchdog();
        test_len_zero();
        test_halt();
        test_write_guard();
        test_random();
        test_reset_replay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
